// File: rtl/mips_mem_responder_pkg.sv
// Shared definitions for the MIPS memory responder: access-size encodings,
// FSM state type and the default array depth.
package mips_mem_responder_pkg;

  localparam int DEFAULT_DEPTH_LOG2 = 10;

  localparam logic [1:0] SEL_WORD    = 2'b00;
  localparam logic [1:0] SEL_HALF    = 2'b01;
  localparam logic [1:0] SEL_BYTE    = 2'b10;
  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Byte-enable mask for a store of the given size at the given lane.
  // Alignment is checked elsewhere; this only steers the lanes.
  function automatic logic [3:0] lane_be(input logic [1:0] sel, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (sel)
      SEL_WORD: be = 4'b1111;
      SEL_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SEL_BYTE: be = 4'b0001 << lane;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mips_mem_responder_mem_lane_array.sv
// DEPTH x 32 storage with one byte-enabled synchronous write port and one
// asynchronous read port. Contents are intentionally not reset so a reset
// of the responder keeps previously loaded code.
module mem_lane_array
  import mips_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Per-lane write; lanes with be low keep their old bytes.
  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Unified I/D memory for the multi-cycle MIPS core. After reset a loader
// fills the array (LOAD) while the core is held in reset; the core then runs
// against it (RUN). A misaligned or out-of-range store latches a sticky
// fault and holds the core in reset until the next RST.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int DEPTH_LOG2       = DEFAULT_DEPTH_LOG2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [ADDRESS_WIDTH-1:0]    Addr,
  input  logic                        MEM_WS,
  input  logic [1:0]                  RAM_SEL,
  input  logic [INSTR_DATA_WIDTH-1:0] Reg2_Out,
  output logic [INSTR_DATA_WIDTH-1:0] DATA,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [DEPTH_LOG2-1:0]       ld_addr,
  input  logic [INSTR_DATA_WIDTH-1:0] ld_data,
  input  logic                        ld_done,
  output logic                        cpu_rst_n,
  output logic                        fault,
  output logic [ADDRESS_WIDTH-1:0]    fault_addr
);

  state_e                state;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  in_range;
  logic                  aligned;
  logic                  legal;
  logic                  ld_fire;
  logic                  core_wr;
  logic                  store_fault;
  logic                  we;
  logic [3:0]            be;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [31:0]           wdata;
  logic [31:0]           rword;

  assign idx      = Addr[DEPTH_LOG2+1:2];
  assign lane     = Addr[1:0];
  assign in_range = ~|Addr[ADDRESS_WIDTH-1:DEPTH_LOG2+2];

  // Alignment check per access size; the illegal encoding never passes.
  always_comb begin
    aligned = 1'b0;
    case (RAM_SEL)
      SEL_WORD: aligned = (lane == 2'b00);
      SEL_HALF: aligned = ~lane[0];
      SEL_BYTE: aligned = 1'b1;
      default:  aligned = 1'b0;
    endcase
  end

  assign legal       = aligned & in_range;
  assign ld_fire     = (state == LOAD) & ld_valid & ld_ready;
  assign core_wr     = (state == RUN) & MEM_WS & legal;
  assign store_fault = (state == RUN) & MEM_WS & ~legal;

  // Single write port shared between loader (LOAD) and core stores (RUN).
  always_comb begin
    if (state == LOAD) begin
      we    = ld_fire;
      be    = 4'b1111;
      waddr = ld_addr;
      wdata = ld_data;
    end else begin
      we    = core_wr;
      be    = lane_be(RAM_SEL, lane);
      waddr = idx;
      case (RAM_SEL)
        SEL_HALF: wdata = {2{Reg2_Out[15:0]}};
        SEL_BYTE: wdata = {4{Reg2_Out[7:0]}};
        default:  wdata = Reg2_Out;
      endcase
    end
  end

  mem_lane_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .CLK   (CLK),
    .we    (we),
    .be    (be),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (idx),
    .rdata (rword)
  );

  // Read formatter: zero-extended lane select, zero in LOAD or when illegal.
  always_comb begin
    DATA = '0;
    if (state != LOAD && legal) begin
      case (RAM_SEL)
        SEL_WORD: DATA = rword;
        SEL_HALF: DATA = {16'h0, rword[16*lane[1] +: 16]};
        SEL_BYTE: DATA = {24'h0, rword[8*lane +: 8]};
        default:  DATA = '0;
      endcase
    end
  end

  // Sequencing FSM; cpu_rst_n follows the state one edge later so the core
  // leaves reset the cycle after RUN is entered and re-enters it after FAULT.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= LOAD;
      ld_ready   <= 1'b0;
      cpu_rst_n  <= 1'b0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      cpu_rst_n <= (state == RUN);
      case (state)
        LOAD: begin
          if (ld_done) begin
            state    <= RUN;
            ld_ready <= 1'b0;
          end else begin
            ld_ready <= 1'b1;
          end
        end
        RUN: begin
          ld_ready <= 1'b0;
          if (store_fault) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_addr <= Addr;
          end
        end
        FAULT: begin
          ld_ready <= 1'b0;
        end
        default: begin
          state    <= FAULT;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: load, sized reads, byte-lane
// stores, fault latching and reset preservation of the array.
module tb_mips_mem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] Addr = '0;
  logic        MEM_WS = 1'b0;
  logic [1:0]  RAM_SEL = 2'b00;
  logic [31:0] Reg2_Out = '0;
  logic [31:0] DATA;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_done = 1'b0;
  logic        cpu_rst_n;
  logic        fault;
  logic [31:0] fault_addr;

  int vectors = 0;
  int errors  = 0;

  mips_mem_responder #(
    .ADDRESS_WIDTH(32),
    .INSTR_DATA_WIDTH(32),
    .DEPTH_LOG2(10)
  ) dut (
    .CLK(CLK), .RST(RST), .Addr(Addr), .MEM_WS(MEM_WS), .RAM_SEL(RAM_SEL),
    .Reg2_Out(Reg2_Out), .DATA(DATA), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .cpu_rst_n(cpu_rst_n), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [1:0] sel,
                    input logic [31:0] exp);
    Addr = a;
    RAM_SEL = sel;
    #1;
    chk(tag, DATA, exp);
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    #9 RST = 1'b1;                      // t=12
    tick();                             // edge at 15
    chk("load_ld_ready", {31'b0, ld_ready}, 32'd1);

    // back-to-back loads, index 3 written twice
    ld_valid = 1'b1; ld_addr = 10'd0; ld_data = 32'h8C010004; tick();
    ld_addr = 10'd1; ld_data = 32'h11223344; tick();
    ld_addr = 10'd3; ld_data = 32'hDEAD0000; tick();
    ld_addr = 10'd3; ld_data = 32'hCAFEF00D; tick();
    ld_valid = 1'b0;
    rd("load_data_zero", 32'd0, 2'b00, 32'd0);
    chk("load_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);

    // final transfer coincides with ld_done
    ld_valid = 1'b1; ld_addr = 10'd2; ld_data = 32'h55667788; ld_done = 1'b1;
    tick();
    ld_valid = 1'b0; ld_done = 1'b0;
    chk("done_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("done_cpu_rst_n_edge", {31'b0, cpu_rst_n}, 32'd0);
    tick();
    chk("run_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd1);

    // sized reads
    rd("rd4_word", 32'd4, 2'b00, 32'h11223344);
    rd("rd4_half", 32'd4, 2'b01, 32'h00003344);
    rd("rd4_byte", 32'd4, 2'b10, 32'h00000044);
    rd("rd6_half", 32'd6, 2'b01, 32'h00001122);
    rd("rd7_byte", 32'd7, 2'b10, 32'h00000011);
    rd("rd5_byte", 32'd5, 2'b10, 32'h00000033);
    rd("rd0_word", 32'd0, 2'b00, 32'h8C010004);
    rd("rd12_last_wins", 32'd12, 2'b00, 32'hCAFEF00D);
    rd("rd8_with_done", 32'd8, 2'b00, 32'h55667788);
    rd("rd5_half_illegal", 32'd5, 2'b01, 32'd0);
    rd("rd4_sel11", 32'd4, 2'b11, 32'd0);
    rd("rd_oor", 32'h00001000, 2'b00, 32'd0);
    chk("rd_oor_no_fault", {31'b0, fault}, 32'd0);

    // byte store at 5; same-cycle read still sees old data
    Addr = 32'd5; RAM_SEL = 2'b10; Reg2_Out = 32'hFFFFFFAB; MEM_WS = 1'b1; #1;
    chk("rdw_old", DATA, 32'h00000033);
    tick();
    Addr = 32'd6; RAM_SEL = 2'b01; Reg2_Out = 32'h0000BEEF; tick();
    MEM_WS = 1'b0;
    rd("after_stores", 32'd4, 2'b00, 32'hBEEFAB44);
    Addr = 32'd0; RAM_SEL = 2'b10; Reg2_Out = 32'h00000012; MEM_WS = 1'b1; tick();
    Addr = 32'd16; RAM_SEL = 2'b00; Reg2_Out = 32'hA5A55A5A; tick();
    MEM_WS = 1'b0;
    rd("byte_lane0", 32'd0, 2'b00, 32'h8C010012);
    rd("word_store", 32'd16, 2'b00, 32'hA5A55A5A);
    chk("no_fault_yet", {31'b0, fault}, 32'd0);

    // misaligned half store at 9
    Addr = 32'd9; RAM_SEL = 2'b01; Reg2_Out = 32'h0000FFFF; MEM_WS = 1'b1; tick();
    MEM_WS = 1'b0;
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_fault_addr", fault_addr, 32'd9);
    chk("mis_cpu_rst_n_edge", {31'b0, cpu_rst_n}, 32'd1);
    rd("mis_mem2", 32'd8, 2'b00, 32'h55667788);
    tick();
    chk("mis_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
    Addr = 32'd8; RAM_SEL = 2'b00; Reg2_Out = 32'h00000000; MEM_WS = 1'b1; tick();
    MEM_WS = 1'b0;
    rd("fault_blocks_wr", 32'd8, 2'b00, 32'h55667788);
    chk("fault_addr_sticky", fault_addr, 32'd9);

    // reset in FAULT, reload handshake, array preserved
    RST = 1'b0; #2;
    chk("rst2_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst2_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
    chk("rst2_fault", {31'b0, fault}, 32'd0);
    chk("rst2_fault_addr", fault_addr, 32'd0);
    RST = 1'b1;
    tick();
    chk("rst2_ld_ready_up", {31'b0, ld_ready}, 32'd1);
    ld_done = 1'b1; tick();
    ld_done = 1'b0; tick();
    chk("rst2_run", {31'b0, cpu_rst_n}, 32'd1);
    rd("preserved_w1", 32'd4, 2'b00, 32'hBEEFAB44);
    rd("preserved_w4", 32'd16, 2'b00, 32'hA5A55A5A);

    // out-of-range store
    Addr = 32'h00001000; RAM_SEL = 2'b00; Reg2_Out = 32'h12345678; MEM_WS = 1'b1; tick();
    MEM_WS = 1'b0;
    chk("oor_fault", {31'b0, fault}, 32'd1);
    chk("oor_fault_addr", fault_addr, 32'h00001000);
    rd("oor_mem0_intact", 32'd0, 2'b00, 32'h8C010012);
    rd("fault_debug_rd", 32'd4, 2'b00, 32'hBEEFAB44);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
